// File: rtl/axis_rotate_hdr_parser.sv
// rtl/axis_rotate_hdr_parser.sv - strips the per-packet rotate header beat and tags payload beats with the command
//
// Ports:
//   aclk, aresetn                  clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tready/tlast  input stream; first beat of each packet is the header
//   m_axis_tdata/tuser/tvalid/tready/tlast  payload stream; tuser = {dir, 0.., amount[3:0]}
//   pkt_count                      completed payload packets, wrapping
//   hdr_err                        one-cycle pulse after a header-only packet

module axis_rotate_hdr_parser #(
    parameter int DATA_WIDTH  = 32,
    parameter int TUSER_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [CNT_WIDTH-1:0]   pkt_count,
    output logic                   hdr_err
);

    localparam int BYTES = DATA_WIDTH / 8;

    // Rotate amount is the header's low log2(BYTES) bits; kept 4 bits wide
    // because that is its field width in tuser.
    localparam logic [3:0] AMT_MASK = (BYTES >= 16) ? 4'hF : 4'(BYTES - 1);

    typedef enum logic [0:0] {
        HDR = 1'b0,
        PAY = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [3:0]             rot_amt;
    logic                   rot_dir;

    logic                   skid_valid;
    logic [DATA_WIDTH-1:0]  skid_tdata;
    logic [TUSER_WIDTH-1:0] skid_tuser;
    logic                   skid_tlast;

    logic                   s_accept;
    logic                   hdr_accept;
    logic                   pay_accept;
    logic                   out_free;
    logic [TUSER_WIDTH-1:0] beat_tuser;

    // Ready depends only on the registered skid flag, so there is no
    // combinational path from m_axis_tready back to the source.
    assign s_axis_tready = aresetn && !skid_valid;

    assign s_accept   = s_axis_tvalid && s_axis_tready;
    assign hdr_accept = s_accept && (state_q == HDR);
    assign pay_accept = s_accept && (state_q == PAY);

    // Output register may take a new beat when empty or draining this cycle.
    assign out_free = !m_axis_tvalid || m_axis_tready;

    // Command sampled into each payload beat as it is accepted.
    always_comb begin
        beat_tuser                  = '0;
        beat_tuser[3:0]             = rot_amt;
        beat_tuser[TUSER_WIDTH-1]   = rot_dir;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR: begin
                if (hdr_accept && !s_axis_tlast) begin
                    state_d = PAY;
                end
            end
            PAY: begin
                if (pay_accept && s_axis_tlast) begin
                    state_d = HDR;
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch, packet counter and header-only error pulse.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rot_amt   <= '0;
            rot_dir   <= 1'b0;
            pkt_count <= '0;
            hdr_err   <= 1'b0;
        end else begin
            hdr_err <= hdr_accept && s_axis_tlast;
            if (hdr_accept) begin
                rot_amt <= s_axis_tdata[3:0] & AMT_MASK;
                rot_dir <= s_axis_tdata[DATA_WIDTH-1];
            end
            if (pay_accept && s_axis_tlast) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

    // Output register plus one-entry skid buffer. The skid buffer only fills
    // while the output register is stalled, and it always empties into the
    // output register before any new input can be accepted.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            skid_valid    <= 1'b0;
            skid_tdata    <= '0;
            skid_tuser    <= '0;
            skid_tlast    <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= skid_tdata;
                m_axis_tuser  <= skid_tuser;
                m_axis_tlast  <= skid_tlast;
                skid_valid    <= 1'b0;
            end else if (pay_accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tuser  <= beat_tuser;
                m_axis_tlast  <= s_axis_tlast;
            end else begin
                m_axis_tvalid <= 1'b0;
            end
        end else if (pay_accept) begin
            skid_valid <= 1'b1;
            skid_tdata <= s_axis_tdata;
            skid_tuser <= beat_tuser;
            skid_tlast <= s_axis_tlast;
        end
    end

endmodule
